tictactoe_ai_mover: RTL and testbench

Automatic computer opponent sitting directly upstream of the `tictactoe` board controller. On a `start` strobe it snapshots the nine board cells, chooses a move with a fixed priority search (win, block, centre, corner, any free cell), then drives `computer_position` and holds `pc` high for a programmable number of cycles so the board controller can commit the move. It is a multi-cycle sequential scanner, one candidate evaluated per clock.

---
 rtl/tictactoe_ai_mover.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tictactoe_ai_mover.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_ai_mover.sv
// tictactoe_ai_mover: automatic computer opponent for the tictactoe board
// controller. On an accepted start it snapshots the board and searches one
// candidate per clock in priority order: win, block, centre, corner, any
// free cell. The chosen cell is presented on computer_position with pc held
// high for PC_HOLD cycles.
// Optional build macro: AI_BLOCK_EN enables the SCAN_BLOCK phase; without it
// the win scan falls straight through to the centre pick.
module tictactoe_ai_mover #(
  parameter int unsigned PC_HOLD = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       busy,
  output logic       no_move
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_WIN,
`ifdef AI_BLOCK_EN
    SCAN_BLOCK,
`endif
    PICK_CENTER,
    PICK_CORNER,
    PICK_ANY,
    HOLD
  } state_t;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;
`ifdef AI_BLOCK_EN
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
`endif
  localparam logic [3:0] LAST_LINE     = 4'd7;
  localparam logic [3:0] LAST_CORNER   = 4'd3;
  localparam logic [3:0] LAST_CELL     = 4'd8;
  localparam logic [3:0] CENTER_CELL   = 4'd4;
  localparam logic [3:0] HOLD_LOAD     = 4'(PC_HOLD - 1);

  // Registered state
  state_t      state;
  logic [3:0]  idx;
  logic [17:0] snap;
  logic [3:0]  hold_cnt;

  // Next-state values
  state_t      state_nxt;
  logic [3:0]  idx_nxt;
  logic [17:0] snap_nxt;
  logic [3:0]  hold_nxt;
  logic [3:0]  pos_nxt;
  logic        pc_nxt;
  logic        busy_nxt;
  logic        no_move_nxt;

  // Candidate evaluation
  logic        hit;
  logic [3:0]  hit_pos;
  logic [4:0]  win_res;
`ifdef AI_BLOCK_EN
  logic [4:0]  blk_res;
`endif
  logic [3:0]  corner;

  // Cell i of a packed board (cell 0 in bits [1:0]).
  function automatic logic [1:0] cell_at(input logic [17:0] b,
                                         input logic [3:0]  i);
    return b[{i, 1'b0} +: 2];
  endfunction

  // The three cell indices of line l, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [3:0] l);
    case (l)
      4'd0:    return {4'd0, 4'd1, 4'd2};
      4'd1:    return {4'd3, 4'd4, 4'd5};
      4'd2:    return {4'd6, 4'd7, 4'd8};
      4'd3:    return {4'd0, 4'd3, 4'd6};
      4'd4:    return {4'd1, 4'd4, 4'd7};
      4'd5:    return {4'd2, 4'd5, 4'd8};
      4'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // {hit, cell}: line l holds exactly two of side and one empty cell.
  function automatic logic [4:0] line_test(input logic [17:0] b,
                                           input logic [3:0]  l,
                                           input logic [1:0]  side);
    logic [11:0] c;
    logic [1:0]  va, vb, vc;
    logic [1:0]  n_side, n_empty;
    logic [3:0]  free;
    c       = line_cells(l);
    va      = cell_at(b, c[11:8]);
    vb      = cell_at(b, c[7:4]);
    vc      = cell_at(b, c[3:0]);
    n_side  = 2'(va == side) + 2'(vb == side) + 2'(vc == side);
    n_empty = 2'(va == CELL_EMPTY) + 2'(vb == CELL_EMPTY) + 2'(vc == CELL_EMPTY);
    if (va == CELL_EMPTY)      free = c[11:8];
    else if (vb == CELL_EMPTY) free = c[7:4];
    else                       free = c[3:0];
    return {(n_side == 2'd2) && (n_empty == 2'd1), free};
  endfunction

  // Corner visiting order 0, 2, 6, 8.
  function automatic logic [3:0] corner_cell(input logic [1:0] k);
    case (k)
      2'd0:    return 4'd0;
      2'd1:    return 4'd2;
      2'd2:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      snap              <= '0;
      hold_cnt          <= '0;
      computer_position <= '0;
      pc                <= 1'b0;
      busy              <= 1'b0;
      no_move           <= 1'b0;
    end else begin
      state             <= state_nxt;
      idx               <= idx_nxt;
      snap              <= snap_nxt;
      hold_cnt          <= hold_nxt;
      computer_position <= pos_nxt;
      pc                <= pc_nxt;
      busy              <= busy_nxt;
      no_move           <= no_move_nxt;
    end
  end

  // Search sequencing: one candidate per cycle, first hit enters HOLD
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    snap_nxt    = snap;
    hold_nxt    = hold_cnt;
    pos_nxt     = computer_position;
    pc_nxt      = pc;
    busy_nxt    = busy;
    no_move_nxt = 1'b0;
    hit         = 1'b0;
    hit_pos     = '0;
    win_res     = line_test(snap, idx, CELL_COMPUTER);
`ifdef AI_BLOCK_EN
    blk_res     = line_test(snap, idx, CELL_PLAYER);
`endif
    corner      = corner_cell(idx[1:0]);

    case (state)
      IDLE: begin
        if (start && (who == 2'b00)) begin
          snap_nxt  = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
          busy_nxt  = 1'b1;
          idx_nxt   = '0;
          state_nxt = SCAN_WIN;
        end
      end

      SCAN_WIN: begin
        if (win_res[4]) begin
          hit     = 1'b1;
          hit_pos = win_res[3:0];
        end else if (idx == LAST_LINE) begin
          idx_nxt   = '0;
`ifdef AI_BLOCK_EN
          state_nxt = SCAN_BLOCK;
`else
          state_nxt = PICK_CENTER;
`endif
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end

`ifdef AI_BLOCK_EN
      SCAN_BLOCK: begin
        if (blk_res[4]) begin
          hit     = 1'b1;
          hit_pos = blk_res[3:0];
        end else if (idx == LAST_LINE) begin
          idx_nxt   = '0;
          state_nxt = PICK_CENTER;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
`endif

      PICK_CENTER: begin
        if (cell_at(snap, CENTER_CELL) == CELL_EMPTY) begin
          hit     = 1'b1;
          hit_pos = CENTER_CELL;
        end else begin
          idx_nxt   = '0;
          state_nxt = PICK_CORNER;
        end
      end

      PICK_CORNER: begin
        if (cell_at(snap, corner) == CELL_EMPTY) begin
          hit     = 1'b1;
          hit_pos = corner;
        end else if (idx == LAST_CORNER) begin
          idx_nxt   = '0;
          state_nxt = PICK_ANY;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end

      PICK_ANY: begin
        if (cell_at(snap, idx) == CELL_EMPTY) begin
          hit     = 1'b1;
          hit_pos = idx;
        end else if (idx == LAST_CELL) begin
          no_move_nxt = 1'b1;
          busy_nxt    = 1'b0;
          idx_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end

      HOLD: begin
        if (hold_cnt == '0) begin
          pc_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Common hit handling: the hit edge is the first of PC_HOLD pc cycles,
    // so the counter starts at PC_HOLD-1 and HOLD exits when it reaches 0.
    if (hit) begin
      pos_nxt   = hit_pos;
      pc_nxt    = 1'b1;
      hold_nxt  = HOLD_LOAD;
      idx_nxt   = '0;
      state_nxt = HOLD;
    end
  end

endmodule

// File: tb/tb_tictactoe_ai_mover.sv
// tb_tictactoe_ai_mover: scoreboard bench for tictactoe_ai_mover.
// Expected moves are pushed when start is driven and popped when pc rises
// or no_move pulses; rise/fall cycles are checked against E0-relative times.
module tb_tictactoe_ai_mover;

  localparam int unsigned HOLD = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] pos1 = '0, pos2 = '0, pos3 = '0, pos4 = '0, pos5 = '0;
  logic [1:0] pos6 = '0, pos7 = '0, pos8 = '0, pos9 = '0;
  logic [1:0] who = '0;
  logic [3:0] computer_position;
  logic       pc, busy, no_move;

  tictactoe_ai_mover #(.PC_HOLD(HOLD)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .who(who), .computer_position(computer_position),
    .pc(pc), .busy(busy), .no_move(no_move)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_move;
    logic [3:0]  pos;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          pc_q = 1'b0, nm_q = 1'b0, in_hold = 1'b0;
  int unsigned fall_due = 0;

  int unsigned lt [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

`ifdef AI_BLOCK_EN
  localparam int unsigned N_EMPTY = 17;
  localparam int unsigned N_NONE  = 30;
`else
  localparam int unsigned N_EMPTY = 9;
  localparam int unsigned N_NONE  = 22;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Board from text: '.' empty, 'P' player, 'C' computer, '#' neither side.
  function automatic logic [17:0] brd(input string s);
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) begin
      case (s[i])
        "P":     b[2*i +: 2] = 2'b01;
        "C":     b[2*i +: 2] = 2'b10;
        "#":     b[2*i +: 2] = 2'b11;
        default: b[2*i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  function automatic bit model_line(input logic [17:0] b, input int l,
                                    input logic [1:0] side, output int unsigned free);
    int mine = 0;
    int empt = 0;
    free = 0;
    for (int k = 0; k < 3; k++) begin
      int unsigned c;
      c = lt[l][k];
      if (b[2*c +: 2] == side) mine++;
      else if (b[2*c +: 2] == 2'b00) begin
        empt++;
        free = c;
      end
    end
    return (mine == 2) && (empt == 1);
  endfunction

  // Reference priority search: returns chosen cell and candidate count n.
  function automatic void model(input logic [17:0] b, output int unsigned pos,
                                output int unsigned n, output bit mv);
    int unsigned f;
    int unsigned cr [4] = '{0, 2, 6, 8};
    n = 0; pos = 0; mv = 1'b1;
    for (int l = 0; l < 8; l++) begin
      n++;
      if (model_line(b, l, 2'b10, f)) begin pos = f; return; end
    end
`ifdef AI_BLOCK_EN
    for (int l = 0; l < 8; l++) begin
      n++;
      if (model_line(b, l, 2'b01, f)) begin pos = f; return; end
    end
`endif
    n++;
    if (b[9:8] == 2'b00) begin pos = 4; return; end
    for (int k = 0; k < 4; k++) begin
      n++;
      if (b[2*cr[k] +: 2] == 2'b00) begin pos = cr[k]; return; end
    end
    for (int k = 0; k < 9; k++) begin
      n++;
      if (b[2*k +: 2] == 2'b00) begin pos = k; return; end
    end
    mv = 1'b0;
  endfunction

  // Advance to the next falling edge and score any DUT output events there.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (reset) begin
      pc_q = pc; nm_q = no_move; in_hold = 1'b0;
      return;
    end
    if (nm_q) check("nomove_width", no_move, 0);
    if (in_hold && pc) check("busy_in_hold", busy, 1);
    if (pc && !pc_q) begin
      check("sb_pending_pc", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind_move", e.is_move, 1);
        check("position", computer_position, e.pos);
        check("pc_rise_cyc", cyc, e.due);
        fall_due = e.due + HOLD;
        in_hold  = 1'b1;
      end
    end
    if (!pc && pc_q && in_hold) begin
      check("pc_fall_cyc", cyc, fall_due);
      check("busy_at_fall", busy, 0);
      in_hold = 1'b0;
    end
    if (no_move && !nm_q) begin
      check("sb_pending_nm", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind_nomove", e.is_move, 0);
        check("nomove_cyc", cyc, e.due);
        check("busy_at_nomove", busy, 0);
        check("pc_at_nomove", pc, 0);
      end
    end
    pc_q = pc; nm_q = no_move;
  endtask

  task automatic set_board(input logic [17:0] b);
    pos1 = b[1:0];   pos2 = b[3:2];   pos3 = b[5:4];
    pos4 = b[7:6];   pos5 = b[9:8];   pos6 = b[11:10];
    pos7 = b[13:12]; pos8 = b[15:14]; pos9 = b[17:16];
  endtask

  task automatic go(input logic [17:0] b, input int unsigned p,
                    input int unsigned n, input bit mv);
    exp_t e;
    set_board(b);
    who   = 2'b00;
    start = 1'b1;
    e.is_move = mv;
    e.pos     = 4'(p);
    e.due     = cyc + 1 + n;
    sb.push_back(e);
    tick();
    start = 1'b0;
    check("busy_after_E0", busy, 1);
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while ((busy || pc || sb.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    check("drain_busy", busy, 0);
    check("drain_sb", sb.size(), 0);
    tick();
  endtask

  initial begin
    int unsigned p, n, k;
    bit          mv;
    logic [17:0] b;

    // Reset state
    repeat (3) tick();
    check("rst_pos", computer_position, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_nomove", no_move, 0);
    reset = 1'b0;
    tick();

    // Empty board: centre (no win/block possible)
    go(brd("........."), 4, N_EMPTY, 1'b1);
    wait_idle();

    // Immediate win on line 0
    go(brd("CC.PP...."), 2, 1, 1'b1);
    wait_idle();

    // Block vs corner depending on build
`ifdef AI_BLOCK_EN
    go(brd("P.C.P...."), 8, 15, 1'b1);
`else
    go(brd("P.C.P...."), 6, 12, 1'b1);
`endif
    wait_idle();

    // Full board: no move
    go(brd("PCPPCCCPP"), 0, N_NONE, 1'b0);
    wait_idle();

    // start with game over is ignored
    who = 2'b01; start = 1'b1; set_board(brd("........."));
    tick();
    start = 1'b0; who = 2'b00;
    check("gameover_busy", busy, 0);
    repeat (4) tick();
    check("gameover_busy_late", busy, 0);
    check("gameover_pc", pc, 0);

    // start re-pulsed while busy: only one move
    go(brd("........."), 4, N_EMPTY, 1'b1);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    // Board change during search has no effect
    go(brd("........."), 4, N_EMPTY, 1'b1);
    tick();
    pos5 = 2'b01;
    wait_idle();
    set_board('0);

    // Random boards against the reference model
    repeat (12) begin
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'($urandom_range(0, 3));
      model(b, p, n, mv);
      go(b, p, n, mv);
      wait_idle();
    end

    // Asynchronous reset in the middle of HOLD
    go(brd("C........"), 4, N_EMPTY, 1'b1);
    k = 0;
    while (!pc && k < 100) begin tick(); k++; end
    check("hold_reached", pc, 1);
    tick();
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_pos", computer_position, 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_pc", pc, 0);
    check("post_rst_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
